fixed_point_sqrt: RTL
=====================

Name: fixed_point_sqrt

Overview:
Iterative digit-by-digit square root for the Q12.20 `fp` type. It consumes a non-negative sum of squares produced by `fixed_point_alu` (for example x²+y²+z² in the ray-marcher distance path) and returns the vector length in Q12.20. It is multi-cycle, sits between the ALU result register and the distance-estimator stage, and uses a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, total bits of `fp`.
FRAC, 20, fractional bits of `fp`; (WIDTH+FRAC) must be even (elaboration-time check).

Ports:
clk_100mhz  input  1  system clock
sys_rst  input  1  asynchronous, active-high reset
in_valid  input  1  radicand valid
in_ready  output  1  block can accept a radicand
d_in  input  WIDTH  radicand, signed Q12.20 (`fp`)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
res_out  output  WIDTH  root, Q12.20, non-negative
neg_err_out  output  1  radicand was negative; qualified by out_valid

Behaviour:
- Reset values (asynchronous, while sys_rst=1): state=IDLE, in_ready=0, out_valid=0, res_out=0, neg_err_out=0, all internal registers 0. Reset may be asserted at any time; an in-flight operation is discarded and no result is produced.
- RES_BITS = (WIDTH+FRAC)/2 = 26. Computes R = floor(sqrt(X·2^FRAC)), where X is d_in as an unsigned integer. R fits in RES_BITS bits and is zero-extended to WIDTH.
- States:
  - IDLE: in_ready=1. If in_valid=1, latch d_in.
    - If d_in[WIDTH-1]=1 → DONE, with res_out=0 and neg_err_out=1.
    - Otherwise → BUSY, with radicand = {X, FRAC zeros} (WIDTH+FRAC bits), root=0, remainder=0, iteration counter=RES_BITS-1.
  - BUSY: in_ready=0. One result bit per cycle, non-restoring/restoring method:
    - shift the next two radicand bits into the remainder;
    - trial = {root,2'b01};
    - if remainder ≥ trial, subtract it and shift in root bit 1; else shift in root bit 0.
    - When the counter reaches 0, go to DONE and register res_out.
  - DONE: out_valid=1, in_ready=0. res_out and neg_err_out stay stable while out_ready=0. If out_ready=1, go to IDLE; out_valid falls on the next cycle.
- Latency: out_valid rises RES_BITS+1 = 27 edges after the accepting edge for a non-negative input, and 1 edge after for a negative input.
- Throughput: one result per 28 cycles with out_ready held high. No acceptance in the same cycle as result handoff; IDLE is always visited for one cycle.
- in_valid while busy: ignored; the upstream must hold its data, per the valid/ready rule.
- Zero input: runs the full iteration and yields res_out=0, neg_err_out=0.
- Remainder width: RES_BITS+2 bits; no overflow is possible.

Optional Feature:
FP_SQRT_ROUND_EN.
- Defined: after the last iteration, if remainder > root, res_out = root+1 (round to nearest). root+1 never exceeds RES_BITS bits for valid inputs. Adds one cycle: state ROUND between BUSY and DONE, so latency is 28.
- Undefined: truncation (floor), no ROUND state, latency 27.

Decomposition:
- Shared package (types.svh / fixed_point_arith.svh): the `fp` typedef, WIDTH/FRAC constants, and a FP_SQRT_RES_BITS localparam derived from them.
- Sub-module fp_sqrt_step: combinational one-iteration datapath (remainder, root, next two bits in; new remainder and root out). It keeps the FSM module to control logic only.

Test Plan:
- d_in=0x00400000 (4.0), out_ready=1 → after 27 edges, res_out=0x00200000 (2.0), neg_err_out=0.
- d_in=0x00300000 (3.0) → res_out=0x001BB67A without the macro; 0x001BB67B with FP_SQRT_ROUND_EN, latency 28.
- d_in=0x80000000 (negative) → out_valid after 1 edge, res_out=0, neg_err_out=1.
- d_in=0x00100000 (1.0) with out_ready=0 for 10 cycles after out_valid → res_out=0x00100000 held stable, in_ready=0 throughout; then out_ready=1 → IDLE next cycle, in_ready=1.
- Assert sys_rst during BUSY at iteration 10 → all outputs go to 0 immediately. After release, d_in=0x00010000 (1/16) → res_out=0x00040000 (0.25).
- Zero input 0x00000000 and back-to-back inputs held on in_valid → second operand accepted only in IDLE; results 0 and correct root in order.

Source files
------------

// File: rtl/fixed_point_sqrt_pkg.sv
// Shared Q12.20 fixed-point definitions for the square-root unit.
package fixed_point_sqrt_pkg;

  localparam int unsigned FP_WIDTH         = 32;
  localparam int unsigned FP_FRAC          = 20;
  localparam int unsigned FP_SQRT_RES_BITS = (FP_WIDTH + FP_FRAC) / 2;

  typedef logic [FP_WIDTH-1:0] fp;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } sqrt_state_e;

endpackage

// File: rtl/fixed_point_sqrt_step.sv
// One iteration of the restoring digit-by-digit square root (combinational).
module fp_sqrt_step
  import fixed_point_sqrt_pkg::*;
#(
  parameter int unsigned RES_BITS = FP_SQRT_RES_BITS
) (
  input  logic [RES_BITS+1:0] rem_i,
  input  logic [RES_BITS-1:0] root_i,
  input  logic [1:0]          bits_i,
  output logic [RES_BITS+1:0] rem_o,
  output logic [RES_BITS-1:0] root_o
);

  logic [RES_BITS+1:0] shifted;
  logic [RES_BITS+1:0] trial;
  logic                ge;
  logic                unused_hi;

  // The remainder never exceeds 2*root, so its top two bits and the root MSB
  // are always zero while iterating; dropping them keeps the datapath narrow.
  assign unused_hi = ^{rem_i[RES_BITS+1:RES_BITS], root_i[RES_BITS-1]};

  // Bring in the next radicand pair, try subtracting {root,01}, append the root bit.
  always_comb begin
    shifted = {rem_i[RES_BITS-1:0], bits_i};
    trial   = {root_i, 2'b01};
    ge      = (shifted >= trial);
    rem_o   = ge ? (shifted - trial) : shifted;
    root_o  = {root_i[RES_BITS-2:0], ge};
  end

endmodule

// File: rtl/fixed_point_sqrt.sv
// Multi-cycle Q12.20 square root with valid/ready on both sides.
// Optional macro FP_SQRT_ROUND_EN: round-to-nearest via an extra ROUND state.
module fixed_point_sqrt
  import fixed_point_sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = FP_WIDTH,
  parameter int unsigned FRAC  = FP_FRAC
) (
  input  logic             clk_100mhz,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             neg_err_out
);

  localparam int unsigned RB   = (WIDTH + FRAC) / 2;
  localparam int unsigned RADW = WIDTH + FRAC;
  localparam int unsigned CW   = $clog2(RB);

  if (((WIDTH + FRAC) % 2) != 0) begin : g_bad_params
    $error("fixed_point_sqrt: WIDTH+FRAC must be even");
  end

  sqrt_state_e      state_q, state_d;
  logic [RADW-1:0]  rad_q, rad_d;
  logic [RB+1:0]    rem_q, rem_d;
  logic [RB-1:0]    root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_q, neg_d;
  logic [RB+1:0]    step_rem;
  logic [RB-1:0]    step_root;

  fp_sqrt_step #(.RES_BITS(RB)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RADW-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  // State and datapath registers.
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          res_d = '0;
          if (d_in[WIDTH-1]) begin
            neg_d   = 1'b1;
            state_d = DONE;
          end else begin
            neg_d   = 1'b0;
            rad_d   = {d_in, {FRAC{1'b0}}};
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CW'(RB - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d  = step_rem;
        root_d = step_root;
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
`ifdef FP_SQRT_ROUND_EN
          state_d = ROUND;
`else
          res_d          = '0;
          res_d[RB-1:0]  = step_root;
          state_d        = DONE;
`endif
        end
      end
`ifdef FP_SQRT_ROUND_EN
      ROUND: begin
        res_d         = '0;
        res_d[RB-1:0] = (rem_q > {2'b00, root_q}) ? (root_q + RB'(1)) : root_q;
        state_d       = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is forced low while reset is held even though the state is IDLE.
  assign in_ready    = (state_q == IDLE) && !sys_rst;
  assign out_valid   = (state_q == DONE);
  assign res_out     = res_q;
  assign neg_err_out = neg_q;

endmodule
